// File: rtl/riscv_tag_rf_snapshot.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// riscv_tag_rf_snapshot
//
// Bulk save/restore engine for the DIFT tag register file. A save sweeps tag
// addresses 1..NUM_WORDS-1 through one RF read port and packs the tags into
// snap_data_o. A restore unpacks a latched snapshot and writes it back through
// one RF write port. The RF ports are only used in cycles where the core
// grants them (rf_gnt_i). A missing grant stalls the sweep in place.
//
// Optional feature (macro RISCV_TAG_SNAP_PARITY_EN):
//   Save stores the XOR of slots 1..NUM_WORDS-1 in bit 0 of the snapshot.
//   Restore checks that parity at acceptance. A mismatch skips all writes and
//   reports err_o with done_o one cycle after acceptance.
//   Without the macro, slot 0 is 0 on save and ignored on restore. err_o is 0.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_i, op_i      request (accepted only in IDLE), 0 = save / 1 = restore
//   restore_data_i   snapshot to restore, sampled with req_i
//   busy_o, done_o   busy from the cycle after acceptance; 1-cycle done pulse
//   snap_data_o      snapshot register (valid from done_o of a save)
//   err_o            restore rejected on parity, valid with done_o
//   rf_gnt_i         core grants the RF ports this cycle
//   rf_raddr_o       RF read address
//   rf_rdata_i       RF read data (combinational from rf_raddr_o)
//   rf_waddr_o       RF write address
//   rf_wdata_o       RF write data
//   rf_we_o          RF write enable
// -----------------------------------------------------------------------------
module riscv_tag_rf_snapshot #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req_i,
  input  logic                                     op_i,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    restore_data_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    snap_data_o,
  output logic                                     err_o,
  input  logic                                     rf_gnt_i,
  output logic [ADDR_WIDTH-1:0]                    rf_raddr_o,
  input  logic [DATA_WIDTH-1:0]                    rf_rdata_i,
  output logic [ADDR_WIDTH-1:0]                    rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                    rf_wdata_o,
  output logic                                     rf_we_o
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH;
  localparam int SNAP_W    = NUM_WORDS * DATA_WIDTH;
  // Slot 0 is never restored, so only slots 1..NUM_WORDS-1 are latched.
  localparam int BODY_W    = SNAP_W - DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_RESTORE,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q,   cnt_d;
  logic [SNAP_W-1:0]       snap_q,  snap_d;
  logic [BODY_W-1:0]       body_q,  body_d;

`ifdef RISCV_TAG_SNAP_PARITY_EN
  logic par_q, par_d;       // running XOR of tags captured so far in a save
  logic err_q, err_d;       // latched parity rejection of the current restore
  logic req_par_ok;

  assign req_par_ok = ((^restore_data_i[SNAP_W-1:DATA_WIDTH]) == restore_data_i[0]);
`else
  // Slot 0 of a restore snapshot carries no information in this build.
  logic unused_slot0;
  assign unused_slot0 = ^restore_data_i[DATA_WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; next-state logic lives in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= FIRST_ADDR;
      snap_q  <= '0;
      // NOTE: the latched restore snapshot is reset too even though it is only
      // read after a fresh acceptance; this keeps outputs X-free after reset.
      body_q  <= '0;
`ifdef RISCV_TAG_SNAP_PARITY_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      body_q  <= body_d;
`ifdef RISCV_TAG_SNAP_PARITY_EN
      par_q   <= par_d;
      err_q   <= err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    body_d  = body_q;
`ifdef RISCV_TAG_SNAP_PARITY_EN
    par_d   = par_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cnt_d  = FIRST_ADDR;
          body_d = restore_data_i[SNAP_W-1:DATA_WIDTH];
`ifdef RISCV_TAG_SNAP_PARITY_EN
          err_d  = 1'b0;
          par_d  = 1'b0;
`endif
          if (!op_i) begin
            // Clearing at acceptance also zeroes slot 0, which no sweep visits.
            snap_d  = '0;
            state_d = S_SAVE;
          end else begin
`ifdef RISCV_TAG_SNAP_PARITY_EN
            if (req_par_ok) begin
              state_d = S_RESTORE;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
`else
            state_d = S_RESTORE;
`endif
          end
        end
      end

      S_SAVE: begin
        if (rf_gnt_i) begin
          for (int k = 1; k < NUM_WORDS; k++) begin
            if (cnt_q == ADDR_WIDTH'(k)) begin
              snap_d[k*DATA_WIDTH +: DATA_WIDTH] = rf_rdata_i;
            end
          end
`ifdef RISCV_TAG_SNAP_PARITY_EN
          par_d = par_q ^ (^rf_rdata_i);
`endif
          // Terminal test before the increment, so cnt never wraps to 0.
          if (cnt_q == LAST_ADDR) begin
`ifdef RISCV_TAG_SNAP_PARITY_EN
            snap_d[DATA_WIDTH-1:0] = '0;
            snap_d[0]              = par_q ^ (^rf_rdata_i);
`endif
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + FIRST_ADDR;
          end
        end
      end

      S_RESTORE: begin
        if (rf_gnt_i) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + FIRST_ADDR;
          end
        end
      end

      // The RF commits write data one cycle late; this idle cycle lets the
      // last tag land before done_o is seen by the core.
      S_FLUSH: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the current state so that reset removes rf_we_o
  // without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o     = (state_q == S_SAVE) || (state_q == S_RESTORE) || (state_q == S_FLUSH);
    done_o     = (state_q == S_DONE);
    rf_raddr_o = '0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    rf_we_o    = 1'b0;

    if (state_q == S_SAVE) begin
      rf_raddr_o = cnt_q;
    end

    if (state_q == S_RESTORE) begin
      rf_waddr_o = cnt_q;
      rf_we_o    = rf_gnt_i;
      for (int k = 1; k < NUM_WORDS; k++) begin
        if (cnt_q == ADDR_WIDTH'(k)) begin
          rf_wdata_o = body_q[(k-1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign snap_data_o = snap_q;

`ifdef RISCV_TAG_SNAP_PARITY_EN
  assign err_o = err_q && (state_q == S_DONE);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_tag_rf_snapshot.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_riscv_tag_rf_snapshot
//
// Drives riscv_tag_rf_snapshot against a behavioural 32 x 1-bit tag RF.
// Each operation pushes its expected completion (cycle, snapshot, err) and, for
// restores, its expected write sequence; both are popped and compared when the
// DUT completes. Cycle n is the n-th cycle after the accepting clock edge.
// -----------------------------------------------------------------------------
module tb_riscv_tag_rf_snapshot;

  localparam int AW = 5;
  localparam int DW = 1;
  localparam int NW = 32;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_i;
  logic          op_i;
  logic [NW-1:0] restore_data_i;
  logic          busy_o;
  logic          done_o;
  logic [NW-1:0] snap_data_o;
  logic          err_o;
  logic          rf_gnt_i;
  logic [AW-1:0] rf_raddr_o;
  logic [DW-1:0] rf_rdata_i;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_we_o;

  riscv_tag_rf_snapshot #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .op_i           (op_i),
    .restore_data_i (restore_data_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .snap_data_o    (snap_data_o),
    .err_o          (err_o),
    .rf_gnt_i       (rf_gnt_i),
    .rf_raddr_o     (rf_raddr_o),
    .rf_rdata_i     (rf_rdata_i),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .rf_we_o        (rf_we_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural tag RF: combinational read, write committed at the clock edge.
  logic [NW-1:0] rf_tags;
  assign rf_rdata_i = rf_tags[rf_raddr_o];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  typedef struct {
    int            cycles;
    logic [NW-1:0] snap;
    logic          err;
  } done_t;

  wr_t   obs_wr_q[$];
  wr_t   exp_wr_q[$];
  done_t exp_q[$];
  int    bad_we = 0;
  logic [NW-1:0] snap_model = '0;

  always @(posedge clk) begin
    if (rf_we_o) begin
      if (!rf_gnt_i || rf_waddr_o == '0) bad_we++;
      obs_wr_q.push_back('{addr: rf_waddr_o, data: rf_wdata_o[0]});
      if (rf_waddr_o != '0) rf_tags[rf_waddr_o] <= rf_wdata_o[0];
    end
  end

  // Snapshot a correct save would produce from the current RF contents.
  function automatic logic [NW-1:0] snap_of_tags();
    logic [NW-1:0] s;
    s    = rf_tags;
    s[0] = 1'b0;
`ifdef RISCV_TAG_SNAP_PARITY_EN
    s[0] = ^s[NW-1:1];
`endif
    return s;
  endfunction

  function automatic logic restore_accepted(input logic [NW-1:0] d);
`ifdef RISCV_TAG_SNAP_PARITY_EN
    return ((^d[NW-1:1]) == d[0]);
`else
    return 1'b1;
`endif
  endfunction

  // Push the scoreboard entries for a restore and return the expected RF.
  task automatic expect_restore(input logic [NW-1:0] d, output logic [NW-1:0] tags_exp);
    if (restore_accepted(d)) begin
      exp_q.push_back('{cycles: NW + 1, snap: snap_model, err: 1'b0});
      for (int k = 1; k < NW; k++) exp_wr_q.push_back('{addr: AW'(k), data: d[k]});
      tags_exp = {d[NW-1:1], rf_tags[0]};
    end else begin
      exp_q.push_back('{cycles: 1, snap: snap_model, err: 1'b1});
      tags_exp = rf_tags;
    end
  endtask

  // Issue one request and run it to completion, collecting observations.
  task automatic run_op(input logic op, input logic [NW-1:0] d, input bit stall,
                        output int cyc, output logic [NW-1:0] snap, output logic err,
                        output logic busy_at_done, output logic done_next,
                        output int busy_bad, output int raddr_bad);
    logic          prev_gnt;
    logic [AW-1:0] prev_raddr;
    cyc = -1; snap = 'x; err = 1'bx; busy_at_done = 1'bx; done_next = 1'bx;
    busy_bad = 0; raddr_bad = 0;
    prev_gnt = 1'b1; prev_raddr = '0;
    obs_wr_q.delete();
    @(negedge clk);
    req_i = 1'b1; op_i = op; restore_data_i = d; rf_gnt_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      rf_gnt_i = stall ? (c % 2 == 0) : 1'b1;
      #1;
      if (done_o === 1'b1) begin
        cyc = c; snap = snap_data_o; err = err_o; busy_at_done = busy_o;
        break;
      end
      if (busy_o !== 1'b1) busy_bad++;
      if (c > 1 && !prev_gnt && rf_raddr_o !== prev_raddr) raddr_bad++;
      prev_gnt = rf_gnt_i; prev_raddr = rf_raddr_o;
      @(posedge clk); #1;
    end
    rf_gnt_i = 1'b1;
    @(posedge clk); #1;
    done_next = done_o;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; req_i = 1'b0; op_i = 1'b0; restore_data_i = '0; rf_gnt_i = 1'b1;
    rf_tags = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
    checks++; if (snap_data_o !== '0) begin failures++; $display("FAIL reset_snap got=%h exp=0", snap_data_o); end
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we_o); end
    checks++; if ({rf_raddr_o, rf_waddr_o, rf_wdata_o} !== '0) begin
      failures++; $display("FAIL reset_addr got=%h/%h/%h exp=0/0/0", rf_raddr_o, rf_waddr_o, rf_wdata_o);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_save(input string name, input bit stall, input int exp_cycles);
    int cyc, busy_bad, raddr_bad; logic [NW-1:0] snap; logic err, bad, dn; done_t e;
    e = '{cycles: exp_cycles, snap: snap_of_tags(), err: 1'b0};
    exp_q.push_back(e);
    snap_model = e.snap;
    run_op(1'b0, '0, stall, cyc, snap, err, bad, dn, busy_bad, raddr_bad);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL %s_scoreboard_empty", name); return; end
    e = exp_q.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc, e.cycles); end
    checks++; if (snap !== e.snap) begin failures++; $display("FAIL %s_snap got=%h exp=%h", name, snap, e.snap); end
    checks++; if (err !== e.err) begin failures++; $display("FAIL %s_err got=%b exp=%b", name, err, e.err); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%b exp=0", name, bad); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%b exp=0", name, dn); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL %s_busy_low got=%0d exp=0", name, busy_bad); end
    checks++; if (raddr_bad != 0) begin failures++; $display("FAIL %s_raddr_hold got=%0d exp=0", name, raddr_bad); end
    checks++; if (obs_wr_q.size() != 0) begin failures++; $display("FAIL %s_writes got=%0d exp=0", name, obs_wr_q.size()); end
  endtask

  task automatic test_save_full();
    rf_tags = 32'hAAAA_AAAA;
    test_save("save_full", 1'b0, NW);
    checks++;
    if (snap_data_o !== 32'hAAAA_AAAA) begin
      failures++; $display("FAIL save_full_pattern got=%h exp=aaaaaaaa", snap_data_o);
    end
  endtask

  task automatic test_save_stall();
    rf_tags = 32'hAAAA_AAAA;
    test_save("save_stall", 1'b1, 2 * NW - 1);
  endtask

  task automatic test_restore(input string name, input logic [NW-1:0] d, input logic [NW-1:0] pre);
    int cyc, busy_bad, raddr_bad, nwr; logic [NW-1:0] snap, tags_exp; logic err, bad, dn;
    done_t e; wr_t we, wo;
    rf_tags = pre;
    exp_wr_q.delete();
    expect_restore(d, tags_exp);
    run_op(1'b1, d, 1'b0, cyc, snap, err, bad, dn, busy_bad, raddr_bad);
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL %s_scoreboard_empty", name); return; end
    e = exp_q.pop_front();
    checks++; if (cyc !== e.cycles) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc, e.cycles); end
    checks++; if (err !== e.err) begin failures++; $display("FAIL %s_err got=%b exp=%b", name, err, e.err); end
    checks++; if (snap !== e.snap) begin failures++; $display("FAIL %s_snap_untouched got=%h exp=%h", name, snap, e.snap); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL %s_busy_low got=%0d exp=0", name, busy_bad); end
    nwr = exp_wr_q.size();
    checks++; if (obs_wr_q.size() != nwr) begin failures++; $display("FAIL %s_write_count got=%0d exp=%0d", name, obs_wr_q.size(), nwr); end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      we = exp_wr_q.pop_front();
      wo = obs_wr_q.pop_front();
      checks++;
      if (wo !== we) begin
        failures++; $display("FAIL %s_write got=%0d:%b exp=%0d:%b", name, wo.addr, wo.data, we.addr, we.data);
      end
    end
    checks++; if (rf_tags !== tags_exp) begin failures++; $display("FAIL %s_readback got=%h exp=%h", name, rf_tags, tags_exp); end
  endtask

  task automatic test_restore_basic();
    test_restore("restore", 32'h8000_0003, 32'h5555_5554);
  endtask

  task automatic test_restore_reset();
    bit found;
    logic [NW-1:0] d;
    d = 32'hFFFF_FFFF;
    rf_tags = '0;
    found = 1'b0;
    @(negedge clk);
    req_i = 1'b1; op_i = 1'b1; restore_data_i = d; rf_gnt_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      #1;
      if (rf_we_o === 1'b1 && rf_waddr_o === AW'(10)) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rst_mid_reach got=timeout exp=write_10"); end
    rst = 1'b1;
    #1;
    snap_model = '0;
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=0", rf_we_o); end
    checks++; if ({busy_o, done_o, err_o} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags got=%b exp=000", {busy_o, done_o, err_o}); end
    checks++; if ({rf_waddr_o, rf_wdata_o, rf_raddr_o} !== '0) begin failures++; $display("FAIL rst_mid_addr got=%h/%h/%h exp=0/0/0", rf_waddr_o, rf_wdata_o, rf_raddr_o); end
    checks++; if (snap_data_o !== '0) begin failures++; $display("FAIL rst_mid_snap got=%h exp=0", snap_data_o); end
    @(negedge clk); rst = 1'b0;
    checks++; if (rf_tags !== 32'h0000_03FE) begin failures++; $display("FAIL rst_mid_partial got=%h exp=000003fe", rf_tags); end
    test_save("after_rst_save", 1'b0, NW);
  endtask

  task automatic test_req_ignored();
    int done_cnt, first_done, busy_after;
    done_t e;
    rf_tags = 32'h1234_5678;
    e = '{cycles: NW, snap: snap_of_tags(), err: 1'b0};
    exp_q.push_back(e);
    snap_model = e.snap;
    obs_wr_q.delete();
    done_cnt = 0; first_done = -1; busy_after = 0;
    @(negedge clk);
    req_i = 1'b1; op_i = 1'b0; restore_data_i = 32'hFFFF_FFFF; rf_gnt_i = 1'b1;
    @(posedge clk); #1;
    op_i = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      #1;
      if (done_o === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
      if (first_done > 0 && c > first_done && busy_o !== 1'b0) busy_after++;
      // Held during early SAVE cycles and again during DONE: both must be dropped.
      req_i = (c < 4) || (done_o === 1'b1);
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL ignore_scoreboard_empty"); return; end
    e = exp_q.pop_front();
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    checks++; if (first_done != e.cycles) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", first_done, e.cycles); end
    checks++; if (busy_after != 0) begin failures++; $display("FAIL ignore_busy_after got=%0d exp=0", busy_after); end
    checks++; if (obs_wr_q.size() != 0) begin failures++; $display("FAIL ignore_writes got=%0d exp=0", obs_wr_q.size()); end
    checks++; if (snap_data_o !== e.snap) begin failures++; $display("FAIL ignore_snap got=%h exp=%h", snap_data_o, e.snap); end
  endtask

`ifdef RISCV_TAG_SNAP_PARITY_EN
  task automatic test_parity();
    test_restore("parity_bad", 32'h0000_0002, 32'h0F0F_0F0E);
    test_restore("parity_good", 32'h0000_0003, 32'h0000_0000);
    checks++; if (rf_tags[1] !== 1'b1) begin failures++; $display("FAIL parity_good_reg1 got=%b exp=1", rf_tags[1]); end
  endtask
`endif

  task automatic test_we_rules();
    checks++; if (bad_we != 0) begin failures++; $display("FAIL we_rules got=%0d exp=0", bad_we); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_save_full();
    test_restore_basic();
    test_save_stall();
    test_restore_reset();
    test_req_ignored();
`ifdef RISCV_TAG_SNAP_PARITY_EN
    test_parity();
`endif
    test_we_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
